// File: rtl/page_pkg.sv
// Shared types and encodings for the page directory controller.
// Pure declarations, no logic.
// No handshake of its own.
package page_pkg;

  localparam int REF_W_DEF = 16;
  localparam int IDX_W_DEF = 8;

  // Directory entry status; 2'b10 is reserved and handled as invalid.
  localparam logic [1:0] ST_INV   = 2'b00;
  localparam logic [1:0] ST_CLEAN = 2'b01;
  localparam logic [1:0] ST_DIRTY = 2'b11;

  // Externally visible controller status.
  localparam logic [1:0] STS_IDLE  = 2'b00;
  localparam logic [1:0] STS_BUSY  = 2'b01;
  localparam logic [1:0] STS_FAULT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_COMPARE,
    S_UPDATE,
    S_FAULT,
    S_FILL,
    S_DONE
  } state_t;

endpackage

// File: rtl/page_rr_arb.sv
// Two-way round-robin arbiter picking one requester per enabled cycle.
// Combinational pick, pointer updates on the edge that accepts a pick.
// Disabled (en=0) means no pick and the pointer holds.
module page_rr_arb (
  input  logic       SCLK,
  input  logic       SRST,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] pick
);

  logic rr_q;  // requester favoured when both ask

  // Pick the favoured requester on contention, else whichever asks.
  always_comb begin
    pick = 2'b00;
    if (en) begin
      if (req == 2'b11) pick = rr_q ? 2'b10 : 2'b01;
      else              pick = req;
    end
  end

  // Point away from the requester just served.
  always_ff @(posedge SCLK) begin
    if (SRST)       rr_q <= 1'b0;
    else if (|pick) rr_q <= ~pick[1];
  end

endmodule

// File: rtl/page_dir_ctrl.sv
// Page directory lookup/dirty-mark/fault-fill sequencer shared by two requesters.
// Read hit at probe k completes 3+2k cycles after the grant edge; clean write hit +1.
// One access in flight; PLCK blocks new grants only; FAULT waits on SINT indefinitely.
module page_dir_ctrl
  import page_pkg::*;
#(
  parameter int REF_W     = REF_W_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int MAX_PROBE = 4
) (
  input  logic             SCLK,
  input  logic             SRST,
  input  logic [1:0]       req,
  input  logic [REF_W-1:0] req_ref0,
  input  logic [REF_W-1:0] req_ref1,
  input  logic [1:0]       RW,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             hit,
  output logic [IDX_W-1:0] idx,
  input  logic             PLCK,
  input  logic             SINT,
  output logic             PINV,
  output logic [1:0]       STATUS,
  output logic             tbl_rd_en,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [REF_W-1:0] tbl_rd_ref,
  input  logic [1:0]       tbl_rd_status,
  output logic             tbl_wr_en,
  output logic [REF_W-1:0] tbl_wr_ref,
  output logic [1:0]       tbl_wr_status
);

  // Probe count and victim counter wrap share the same power-of-two mask.
  localparam logic [IDX_W-1:0] LAST_PROBE = IDX_W'(MAX_PROBE - 1);

  state_t           state, state_nxt;
  logic [1:0]       pick;
  logic             arb_en;
  logic [REF_W-1:0] sel_ref;
  logic             id_q, rw_q, gnt_pend_q;
  logic [REF_W-1:0] pref_q;
  logic [IDX_W-1:0] base_q, probe_q, probe_idx;
  logic             free_found_q;
  logic [IDX_W-1:0] free_idx_q, victim_q, victim_ctr_q, res_idx_q;
  logic             res_hit_q;
  logic             cmp_hit;

  assign arb_en    = ~PLCK & (state == S_IDLE);
  assign sel_ref   = pick[1] ? req_ref1 : req_ref0;
  assign probe_idx = base_q + probe_q;
  assign cmp_hit   = tbl_rd_status[0] & (tbl_rd_ref == pref_q);

  page_rr_arb u_arb (
    .SCLK (SCLK),
    .SRST (SRST),
    .req  (req),
    .en   (arb_en),
    .pick (pick)
  );

  // State register.
  always_ff @(posedge SCLK) begin
    if (SRST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state and Moore outputs; everything idles at zero.
  always_comb begin
    state_nxt     = state;
    gnt           = 2'b00;
    done          = 2'b00;
    hit           = 1'b0;
    idx           = '0;
    PINV          = 1'b0;
    STATUS        = STS_BUSY;
    tbl_rd_en     = 1'b0;
    tbl_idx       = '0;
    tbl_wr_en     = 1'b0;
    tbl_wr_ref    = '0;
    tbl_wr_status = ST_INV;
    case (state)
      S_IDLE: begin
        STATUS = STS_IDLE;
        if (|pick) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        gnt[id_q] = gnt_pend_q;
        tbl_rd_en = 1'b1;
        tbl_idx   = probe_idx;
        state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        if (cmp_hit)
          state_nxt = (rw_q && tbl_rd_status == ST_CLEAN) ? S_UPDATE : S_DONE;
        else
          state_nxt = (probe_q < LAST_PROBE) ? S_ISSUE : S_FAULT;
      end
      S_UPDATE: begin
        tbl_wr_en     = 1'b1;
        tbl_idx       = probe_idx;
        tbl_wr_ref    = pref_q;
        tbl_wr_status = ST_DIRTY;
        state_nxt     = S_DONE;
      end
      S_FAULT: begin
        PINV   = 1'b1;
        STATUS = STS_FAULT;
        if (SINT) state_nxt = S_FILL;
      end
      S_FILL: begin
        tbl_wr_en     = 1'b1;
        tbl_idx       = victim_q;
        tbl_wr_ref    = pref_q;
        tbl_wr_status = rw_q ? ST_DIRTY : ST_CLEAN;
        state_nxt     = S_DONE;
      end
      S_DONE: begin
        done[id_q] = 1'b1;
        hit        = res_hit_q;
        idx        = res_idx_q;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Access context: latched at grant, advanced by probe, resolved at fill.
  always_ff @(posedge SCLK) begin
    if (SRST) begin
      id_q         <= 1'b0;
      rw_q         <= 1'b0;
      gnt_pend_q   <= 1'b0;
      pref_q       <= '0;
      base_q       <= '0;
      probe_q      <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      victim_q     <= '0;
      victim_ctr_q <= '0;
      res_idx_q    <= '0;
      res_hit_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (|pick) begin
          id_q         <= pick[1];
          rw_q         <= RW[pick[1]];
          pref_q       <= sel_ref;
          base_q       <= sel_ref[IDX_W-1:0];
          probe_q      <= '0;
          free_found_q <= 1'b0;
          gnt_pend_q   <= 1'b1;
        end
        S_ISSUE: gnt_pend_q <= 1'b0;
        S_COMPARE: begin
          if (cmp_hit) begin
            res_hit_q <= 1'b1;
            res_idx_q <= probe_idx;
          end else begin
            // Only the first free slot seen is worth remembering.
            if (!tbl_rd_status[0] && !free_found_q) begin
              free_idx_q   <= probe_idx;
              free_found_q <= 1'b1;
            end
            if (probe_q < LAST_PROBE) probe_q <= probe_q + 1'b1;
          end
        end
        S_FAULT: if (SINT)
          victim_q <= free_found_q ? free_idx_q : base_q + victim_ctr_q;
        S_FILL: begin
          res_hit_q <= 1'b0;
          res_idx_q <= victim_q;
          // Rotate the eviction choice only when something was actually evicted.
          if (!free_found_q) victim_ctr_q <= (victim_ctr_q + 1'b1) & LAST_PROBE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_page_dir_ctrl.sv
// Directed bench for page_dir_ctrl with a behavioural directory memory.
// Inputs driven and outputs sampled on the falling edge of SCLK.
// Table of single accesses plus hand sequences for wrap, fault, arbitration, lock, reset.
module tb_page_dir_ctrl;

  logic        SCLK = 1'b0;
  logic        SRST;
  logic [1:0]  req;
  logic [15:0] req_ref0, req_ref1;
  logic [1:0]  RW;
  logic [1:0]  gnt, done;
  logic        hit;
  logic [7:0]  idx;
  logic        PLCK, SINT, PINV;
  logic [1:0]  STATUS;
  logic        tbl_rd_en, tbl_wr_en;
  logic [7:0]  tbl_idx;
  logic [15:0] tbl_rd_ref, tbl_wr_ref;
  logic [1:0]  tbl_rd_status, tbl_wr_status;

  always #5 SCLK = ~SCLK;

  page_dir_ctrl dut (
    .SCLK(SCLK), .SRST(SRST), .req(req), .req_ref0(req_ref0), .req_ref1(req_ref1),
    .RW(RW), .gnt(gnt), .done(done), .hit(hit), .idx(idx), .PLCK(PLCK), .SINT(SINT),
    .PINV(PINV), .STATUS(STATUS), .tbl_rd_en(tbl_rd_en), .tbl_idx(tbl_idx),
    .tbl_rd_ref(tbl_rd_ref), .tbl_rd_status(tbl_rd_status), .tbl_wr_en(tbl_wr_en),
    .tbl_wr_ref(tbl_wr_ref), .tbl_wr_status(tbl_wr_status)
  );

  // Directory model: single writer process, preload/clear via side inputs.
  logic [15:0] mem_ref [256];
  logic [1:0]  mem_st  [256];
  logic        mem_clr = 1'b0, pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [15:0] pl_ref = '0;
  logic [1:0]  pl_st = '0;
  logic [7:0]  rd_log [256];
  logic [7:0]  rd_wp = '0;
  int          wr_cnt = 0;
  logic [7:0]  lw_idx = '0;
  logic [15:0] lw_ref = '0;
  logic [1:0]  lw_st = '0;

  // Synchronous-read directory with write/read logging.
  always @(posedge SCLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem_ref[i] <= '0;
        mem_st[i]  <= '0;
      end
    end else if (pl_en) begin
      mem_ref[pl_idx] <= pl_ref;
      mem_st[pl_idx]  <= pl_st;
    end
    if (tbl_rd_en) begin
      tbl_rd_ref    <= mem_ref[tbl_idx];
      tbl_rd_status <= mem_st[tbl_idx];
      rd_log[rd_wp] <= tbl_idx;
      rd_wp         <= rd_wp + 8'd1;
    end
    if (tbl_wr_en) begin
      mem_ref[tbl_idx] <= tbl_wr_ref;
      mem_st[tbl_idx]  <= tbl_wr_status;
      wr_cnt <= wr_cnt + 1;
      lw_idx <= tbl_idx;
      lw_ref <= tbl_wr_ref;
      lw_st  <= tbl_wr_status;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic pl(input logic [7:0] i, input logic [15:0] r, input logic [1:0] s);
    pl_idx = i; pl_ref = r; pl_st = s; pl_en = 1'b1;
    @(negedge SCLK);
    pl_en = 1'b0;
  endtask

  // Wait (bounded) for a done pulse; latencies count edges from the request-sampling edge.
  task automatic wait_done(input int budget, output int glat, output logic [1:0] gv,
                           output int dlat, output logic [1:0] dv, output logic hv,
                           output logic [7:0] iv);
    glat = -1; gv = '0; dlat = -1; dv = '0; hv = 1'b0; iv = '0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge SCLK);
      if (gnt != 2'b00 && glat < 0) begin glat = c; gv = gnt; end
      if (done != 2'b00) begin dlat = c; dv = done; hv = hit; iv = idx; break; end
    end
  endtask

  task automatic txn(input logic id, input logic [15:0] r, input logic rw, input logic sh,
                     output int glat, output logic [1:0] gv, output int dlat,
                     output logic [1:0] dv, output logic hv, output logic [7:0] iv);
    if (id) req_ref1 = r; else req_ref0 = r;
    RW[id] = rw; req[id] = 1'b1; SINT = sh;
    wait_done(40, glat, gv, dlat, dv, hv, iv);
    req[id] = 1'b0; SINT = 1'b0;
  endtask

  typedef struct {
    logic        id;
    logic [15:0] r;
    logic        rw;
    logic        sint;
    int          lat;
    logic        e_hit;
    logic [7:0]  e_idx;
    int          n_wr;
    logic [7:0]  w_idx;
    logic [15:0] w_ref;
    logic [1:0]  w_st;
  } vec_t;

  vec_t        vecs [7];
  int          glat, dlat, w0, ng;
  logic [1:0]  gv, dv;
  logic        hv;
  logic [7:0]  iv, rp0, ix;
  logic [1:0]  gseq [3];
  logic [7:0]  wrap_exp [4];
  logic [1:0]  one_hot;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 16'h0012, 1'b0, 1'b0, 3,  1'b1, 8'h12, 0, 8'h00, 16'h0000, 2'b00};
    vecs[1] = '{1'b1, 16'h0030, 1'b1, 1'b0, 6,  1'b1, 8'h31, 1, 8'h31, 16'h0030, 2'b11};
    vecs[2] = '{1'b0, 16'h0040, 1'b1, 1'b0, 3,  1'b1, 8'h40, 0, 8'h00, 16'h0000, 2'b00};
    vecs[3] = '{1'b1, 16'h0150, 1'b0, 1'b0, 9,  1'b1, 8'h53, 0, 8'h00, 16'h0000, 2'b00};
    vecs[4] = '{1'b0, 16'h0060, 1'b0, 1'b0, 5,  1'b1, 8'h61, 0, 8'h00, 16'h0000, 2'b00};
    vecs[5] = '{1'b1, 16'h0070, 1'b1, 1'b1, 11, 1'b0, 8'h71, 1, 8'h71, 16'h0070, 2'b11};
    vecs[6] = '{1'b0, 16'h0030, 1'b1, 1'b0, 5,  1'b1, 8'h31, 0, 8'h00, 16'h0000, 2'b00};
    wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;

    SRST = 1'b1; req = '0; req_ref0 = '0; req_ref1 = '0; RW = '0; PLCK = 1'b0; SINT = 1'b0;
    mem_clr = 1'b1;
    repeat (2) @(negedge SCLK);
    mem_clr = 1'b0;
    chk("rst_status", 32'(STATUS), 32'h0);
    chk("rst_pinv", 32'(PINV), 32'h0);
    chk("rst_gnt_done", 32'({gnt, done}), 32'h0);
    chk("rst_tbl_en", 32'({tbl_rd_en, tbl_wr_en}), 32'h0);
    chk("rst_hit_idx", 32'({hit, idx}), 32'h0);
    SRST = 1'b0;

    pl(8'h12, 16'h0012, 2'b01);
    pl(8'h31, 16'h0030, 2'b01);
    pl(8'h40, 16'h0040, 2'b11);
    pl(8'h50, 16'h1150, 2'b01);
    pl(8'h51, 16'h0050, 2'b01);
    pl(8'h52, 16'h2250, 2'b11);
    pl(8'h53, 16'h0150, 2'b11);
    pl(8'h60, 16'h0060, 2'b10);
    pl(8'h61, 16'h0060, 2'b01);
    pl(8'h70, 16'h1170, 2'b01);
    pl(8'h72, 16'h5555, 2'b10);
    pl(8'h73, 16'h2270, 2'b11);
    @(negedge SCLK);

    for (int i = 0; i < 7; i++) begin
      w0 = wr_cnt;
      one_hot = vecs[i].id ? 2'b10 : 2'b01;
      txn(vecs[i].id, vecs[i].r, vecs[i].rw, vecs[i].sint, glat, gv, dlat, dv, hv, iv);
      chk($sformatf("v%0d_gnt_lat", i), 32'(glat), 32'd1);
      chk($sformatf("v%0d_gnt", i), 32'(gv), 32'(one_hot));
      chk($sformatf("v%0d_done_lat", i), 32'(dlat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_done", i), 32'(dv), 32'(one_hot));
      chk($sformatf("v%0d_hit", i), 32'(hv), 32'(vecs[i].e_hit));
      chk($sformatf("v%0d_idx", i), 32'(iv), 32'(vecs[i].e_idx));
      chk($sformatf("v%0d_nwr", i), 32'(wr_cnt - w0), 32'(vecs[i].n_wr));
      if (vecs[i].n_wr != 0)
        chk($sformatf("v%0d_wr", i), {6'd0, lw_idx, lw_ref, lw_st}, {6'd0, vecs[i].w_idx, vecs[i].w_ref, vecs[i].w_st});
      @(negedge SCLK);
    end

    // Wrap-around probe, fault held until SINT, fill into victim base+0.
    pl(8'hFE, 16'h11FE, 2'b01);
    pl(8'hFF, 16'h22FF, 2'b01);
    pl(8'h00, 16'h3300, 2'b11);
    pl(8'h01, 16'h4401, 2'b01);
    rp0 = rd_wp; w0 = wr_cnt;
    req_ref0 = 16'h00FE; RW = 2'b00; req = 2'b01;
    ng = 0;
    for (int c = 0; c < 30 && !PINV; c++) @(negedge SCLK);
    chk("wrap_pinv", 32'(PINV), 32'h1);
    for (int k = 0; k < 4; k++) begin
      ix = rp0 + 8'(k);
      chk($sformatf("wrap_rd%0d", k), 32'(rd_log[ix]), 32'(wrap_exp[k]));
    end
    repeat (3) begin
      @(negedge SCLK);
      chk("fault_hold", 32'({PINV, STATUS, done}), 32'b1_10_00);
    end
    SINT = 1'b1;
    @(negedge SCLK);
    SINT = 1'b0;
    wait_done(10, glat, gv, dlat, dv, hv, iv);
    req = 2'b00;
    chk("wrap_done", 32'(dv), 32'h1);
    chk("wrap_hit_idx", 32'({hv, iv}), 32'({1'b0, 8'hFE}));
    chk("wrap_wr", {wr_cnt - w0 == 1, lw_idx, lw_ref, lw_st}, {1'b1, 8'hFE, 16'h00FE, 2'b01});
    @(negedge SCLK);
    w0 = wr_cnt;
    txn(1'b0, 16'h01FE, 1'b0, 1'b1, glat, gv, dlat, dv, hv, iv);
    chk("miss2_lat", 32'(dlat), 32'd11);
    chk("miss2_hit_idx", 32'({hv, iv}), 32'({1'b0, 8'hFF}));
    chk("miss2_wr", {wr_cnt - w0 == 1, lw_idx, lw_ref, lw_st}, {1'b1, 8'hFF, 16'h01FE, 2'b01});
    @(negedge SCLK);

    // Both requesting continuously: 0 first after reset, then alternate.
    SRST = 1'b1;
    repeat (2) @(negedge SCLK);
    SRST = 1'b0;
    req_ref0 = 16'h0012; req_ref1 = 16'h0040; RW = 2'b00; req = 2'b11;
    ng = 0;
    for (int c = 0; c < 60 && ng < 3; c++) begin
      @(negedge SCLK);
      if (gnt != 2'b00) begin gseq[ng] = gnt; ng++; end
    end
    wait_done(10, glat, gv, dlat, dv, hv, iv);
    req = 2'b00;
    chk("arb_cnt", 32'(ng), 32'd3);
    chk("arb_g0", 32'(gseq[0]), 32'h1);
    chk("arb_g1", 32'(gseq[1]), 32'h2);
    chk("arb_g2", 32'(gseq[2]), 32'h1);
    @(negedge SCLK);

    // Lock blocks grants; release grants next edge; relock mid-access is harmless.
    PLCK = 1'b1; req_ref0 = 16'h0012; RW = 2'b00; req = 2'b01;
    ng = 0;
    repeat (5) begin
      @(negedge SCLK);
      if (gnt != 2'b00) ng++;
    end
    chk("lock_no_gnt", 32'(ng), 32'd0);
    chk("lock_idle", 32'(STATUS), 32'h0);
    PLCK = 1'b0;
    @(negedge SCLK);
    chk("unlock_gnt", 32'(gnt), 32'h1);
    PLCK = 1'b1;
    wait_done(10, glat, gv, dlat, dv, hv, iv);
    req = 2'b00;
    chk("lock_mid_done", 32'(dv), 32'h1);
    chk("lock_mid_hit", 32'({hv, iv}), 32'({1'b1, 8'h12}));
    PLCK = 1'b0;
    @(negedge SCLK);

    // Reset while faulted: abandoned silently, then re-granted.
    w0 = wr_cnt;
    req_ref0 = 16'h0099; RW = 2'b00; req = 2'b01;
    for (int c = 0; c < 30 && !PINV; c++) @(negedge SCLK);
    chk("rstf_pinv", 32'(PINV), 32'h1);
    SRST = 1'b1;
    @(negedge SCLK);
    SRST = 1'b0;
    chk("rstf_out", 32'({PINV, STATUS, done}), 32'h0);
    @(negedge SCLK);
    chk("rstf_regnt", 32'({gnt, done}), 32'b01_00);
    chk("rstf_nowr", 32'(wr_cnt - w0), 32'd0);
    SINT = 1'b1;
    wait_done(20, glat, gv, dlat, dv, hv, iv);
    req = 2'b00; SINT = 1'b0;
    chk("rstf_done", 32'({dv, hv, iv}), 32'({2'b01, 1'b0, 8'h99}));
    chk("rstf_wr", {wr_cnt - w0 == 1, lw_idx, lw_ref, lw_st}, {1'b1, 8'h99, 16'h0099, 2'b01});
    @(negedge SCLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/page_dir_ctrl.md
Name: page_dir_ctrl

Overview:
Sequencing controller for the 256-entry page directory, where each entry holds a 16-bit page ref and 2-bit status. Shares the directory's single read/write port between two requesters: 0 = instruction fetch, 1 = data. For each request it:
- probes up to MAX_PROBE consecutive entries starting at the hashed index and reports hit plus index;
- marks entries dirty on write hits;
- on a miss, raises PINV, waits for SINT service, then installs the page.

Parameters:
REF_W, 16, page ref width
IDX_W, 8, directory index width (2^IDX_W entries)
MAX_PROBE, 4, entries probed per lookup (power of 2, ≤ 2^IDX_W)

Ports:
SCLK  in  1  clock
SRST  in  1  synchronous active-high reset
req  in  2  request per requester; held until its done pulse
req_ref0  in  REF_W  requester 0 page ref; stable while req[0] high
req_ref1  in  REF_W  requester 1 page ref; stable while req[1] high
RW  in  2  per requester: 1 = write access, 0 = read
gnt  out  2  one-hot grant pulse, one cycle
done  out  2  one-hot completion pulse, one cycle
hit  out  1  valid with done: 1 = found, 0 = installed after fault
idx  out  IDX_W  valid with done: entry index
PLCK  in  1  lock: no new grants while high
SINT  in  1  fault-service acknowledge
PINV  out  1  page-invalid fault, high throughout FAULT
STATUS  out  2  00 idle, 01 busy, 10 fault, 11 unused
tbl_rd_en  out  1  directory read strobe
tbl_idx  out  IDX_W  directory index for read or write
tbl_rd_ref  in  REF_W  read ref, valid the cycle after tbl_rd_en
tbl_rd_status  in  2  read status, valid the cycle after tbl_rd_en
tbl_wr_en  out  1  directory write strobe
tbl_wr_ref  out  REF_W  write ref
tbl_wr_status  out  2  write status

Behaviour:
- Status encoding: 00 invalid, 01 valid clean, 11 valid dirty, 10 reserved (treated as invalid).
- Reset (SRST sampled high at an SCLK edge):
  - state IDLE;
  - all outputs 0;
  - rr pointer = 0 (requester 0 favoured);
  - victim_ctr = 0;
  - reset mid-operation abandons the access with no done pulse;
  - directory contents are untouched.
- FSM states: IDLE, ISSUE, COMPARE, UPDATE, FAULT, FILL, DONE.
- IDLE:
  - if PLCK=0 and req≠0, grant the requester;
  - when both request, grant the one favoured by rr, then rr flips to the other;
  - when one requests, grant it; rr flips away from it;
  - latch ref, RW and requester id; probe=0; base = ref[IDX_W-1:0]; free_found=0; go to ISSUE.
- ISSUE: gnt[id]=1 on the first ISSUE only; tbl_rd_en=1; tbl_idx = (base+probe) mod 2^IDX_W (wraps 255→0); go to COMPARE.
- COMPARE:
  - hit when tbl_rd_status[0]=1 and tbl_rd_ref==ref;
  - hit with RW=1 and status 01 → UPDATE; any other hit → DONE with hit=1;
  - no hit: on the first status with bit0=0, record free_idx; free_found=1;
  - if probe<MAX_PROBE-1, increment probe and go to ISSUE; else go to FAULT.
- UPDATE: tbl_wr_en=1; same idx; wr_ref=ref; wr_status=11; go to DONE with hit=1.
- FAULT:
  - PINV=1, STATUS=10;
  - SINT is ignored in every other state;
  - on SINT=1 go to FILL; victim = free_idx if free_found, else (base+victim_ctr) mod 2^IDX_W.
- FILL:
  - tbl_wr_en=1 at victim; wr_ref=ref; wr_status = RW?11:01;
  - victim_ctr increments mod MAX_PROBE only if no free slot was used;
  - go to DONE with hit=0, idx=victim.
- DONE: done[id]=1; go to IDLE. A request can be granted in the following IDLE cycle, not the same one.
- STATUS: 01 in every state except IDLE and FAULT.
- Latency from the req-sampled edge T:
  - gnt at T+1;
  - read hit at probe k: done at T+3+2k;
  - write hit on a clean entry: +1 cycle;
  - write hit on a dirty entry: no extra cycle.
- Only one access is in flight at a time; PLCK changes never abort the in-flight access.

Decomposition:
- Shared package page_pkg:
  - status encodings ST_INV=00, ST_CLEAN=01, ST_DIRTY=11;
  - STATUS codes;
  - FSM state enum;
  - REF_W/IDX_W defaults.
- One sub-module, page_rr_arb: 2-way round-robin arbiter (req, enable=~PLCK&idle → one-hot pick, rr update).

Test Plan:
1. Preload idx 0x12 = {ref 0x0012, 01}; req[0], ref 0x0012, read → gnt[0] at T+1, done[0] at T+3, hit=1, idx=0x12, no tbl_wr_en.
2. Preload idx 0x12 invalid, idx 0x13 = {0x0012, 01}; req[1] write of ref 0x0012 → hit at probe 1; UPDATE writes 0x13 status 11; done at T+6, hit=1.
3. Preload idx 0xFE..0xFF and 0x00..0x01 all valid with other refs; read of ref 0x00FE → probes 0xFE, 0xFF, 0x00, 0x01 (wrap); PINV high, STATUS=10 until SINT pulse; FILL writes idx 0xFE (victim_ctr 0) with {0x00FE, 01}; done hit=0; a second such miss picks 0xFF.
4. req=11 held continuously → grants alternate 0,1,0; first grant to 0 after reset.
5. PLCK=1 with req[0] high → no gnt; PLCK→0 → gnt next cycle; PLCK raised mid-access → access still completes.
6. SRST asserted in FAULT → PINV=0, STATUS=00 next cycle, no done, no table write; the same request is re-granted afterwards.
